// File: rtl/piso_shift_transmitter_pkg.sv
// rtl/piso_shift_transmitter_pkg.sv - shared state encoding and counter sizing for the PISO transmitter
package piso_shift_transmitter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit counter width for a given word size, never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_transmitter_bit_counter.sv
// rtl/piso_shift_transmitter_bit_counter.sv - bit position counter with clear, enable and terminal count
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_transmitter.sv
// rtl/piso_shift_transmitter.sv - parallel-in serial-out transmitter with valid/ready word loading
module piso_shift_transmitter
  import piso_shift_transmitter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W   = cnt_w(WIDTH);
  localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             done_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             tc;
  logic             in_shift;
  logic             last_bit;
  logic             accept;

  assign in_shift   = (state_q == ST_SHIFT);
  assign last_bit   = in_shift & tc;
  // A new word may be taken while the final bit of the previous one is on the line.
  assign load_ready = !rst & ((state_q == ST_IDLE) | last_bit);
  assign accept     = load_valid & load_ready;

  shift_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr_i(accept | last_bit),
    .en_i (in_shift),
    .cnt_o(bit_cnt),
    .tc_o (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= last_bit;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (tc && !accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = load_data;
    end else if (last_bit) begin
      shreg_d = '0;
    end else if (in_shift) begin
      if (MSB_FIRST) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    busy       = in_shift;
    sout_valid = in_shift;
    last       = last_bit;
    sout       = in_shift & shreg_q[OUT_IDX];
    done       = done_q;
  end

  logic unused_cnt;
  assign unused_cnt = ^bit_cnt;

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// tb/tb_piso_shift_transmitter.sv - scoreboard bench for three transmitter configurations
module tb_piso_shift_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] lv;
  logic [7:0] ld0;
  logic [7:0] ld1;
  logic [1:0] ld2;
  logic [2:0] rdy, so, sv, la, bz, dn;

  always #5 clk = ~clk;

  piso_shift_transmitter #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]), .load_data(ld0),
    .sout(so[0]), .sout_valid(sv[0]), .last(la[0]), .busy(bz[0]), .done(dn[0]));

  piso_shift_transmitter #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]), .load_data(ld1),
    .sout(so[1]), .sout_valid(sv[1]), .last(la[1]), .busy(bz[1]), .done(dn[1]));

  piso_shift_transmitter #(.WIDTH(2), .MSB_FIRST(1'b1)) dut_w2 (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(rdy[2]), .load_data(ld2),
    .sout(so[2]), .sout_valid(sv[2]), .last(la[2]), .busy(bz[2]), .done(dn[2]));

  // Each entry is {last, bit} for one expected serial cycle.
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];
  logic [2:0] exp_done = '0;
  logic [2:0] acc = '0;
  int vectors = 0;
  int miscompares = 0;

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [1:0] qhead(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int k, input logic [1:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic logic [31:0] cur_data(input int k);
    case (k)
      0: return {24'd0, ld0};
      1: return {24'd0, ld1};
      default: return {30'd0, ld2};
    endcase
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic push_word(input int k, input logic [31:0] d);
    int w;
    bit msb;
    logic b;
    w   = (k == 2) ? 2 : 8;
    msb = (k != 1);
    for (int i = 0; i < w; i++) begin
      b = msb ? d[w-1-i] : d[i];
      qpush(k, {(i == w - 1), b});
    end
  endtask

  task automatic monitor();
    logic [1:0] e;
    logic er;
    logic nd;
    for (int k = 0; k < 3; k++) begin
      er = 1'b0;
      if (!rst) begin
        if (qsize(k) == 0) begin
          er = 1'b1;
        end else begin
          e  = qhead(k);
          er = e[1];
        end
      end
      chk("load_ready", k, {31'd0, rdy[k]}, {31'd0, er});
      chk("done", k, {31'd0, dn[k]}, {31'd0, exp_done[k]});
      if (qsize(k) > 0) begin
        e = qhead(k);
        qpop(k);
        chk("sout_valid", k, {31'd0, sv[k]}, 32'd1);
        chk("sout", k, {31'd0, so[k]}, {31'd0, e[0]});
        chk("last", k, {31'd0, la[k]}, {31'd0, e[1]});
        chk("busy", k, {31'd0, bz[k]}, 32'd1);
        nd = e[1];
      end else begin
        chk("sout_valid", k, {31'd0, sv[k]}, 32'd0);
        chk("sout", k, {31'd0, so[k]}, 32'd0);
        chk("last", k, {31'd0, la[k]}, 32'd0);
        chk("busy", k, {31'd0, bz[k]}, 32'd0);
        nd = 1'b0;
      end
      exp_done[k] = nd;
      acc[k]      = lv[k] & er;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (acc[k]) push_word(k, cur_data(k));
    end
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] d);
    int n;
    case (k)
      0: ld0 = d;
      1: ld1 = d;
      default: ld2 = d[1:0];
    endcase
    lv[k] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc[k] && n < 40);
    chk("accepted", k, {31'd0, acc[k]}, 32'd1);
    lv[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qsize(0) + qsize(1) + qsize(2) > 0 || exp_done != 3'b000) && n < 100) begin
      tick();
      n++;
    end
    chk("drained", 0, qsize(0) + qsize(1) + qsize(2), 32'd0);
    tick();
  endtask

  task automatic check_quiet(input int k);
    chk("rst_sout", k, {31'd0, so[k]}, 32'd0);
    chk("rst_sout_valid", k, {31'd0, sv[k]}, 32'd0);
    chk("rst_last", k, {31'd0, la[k]}, 32'd0);
    chk("rst_busy", k, {31'd0, bz[k]}, 32'd0);
    chk("rst_done", k, {31'd0, dn[k]}, 32'd0);
    chk("rst_load_ready", k, {31'd0, rdy[k]}, 32'd0);
  endtask

  initial begin
    lv  = '0;
    ld0 = '0;
    ld1 = '0;
    ld2 = '0;
    rst = 1'b1;
    #23;
    for (int k = 0; k < 3; k++) check_quiet(k);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    send(0, 8'hA5);
    drain();

    send(1, 8'h01);
    drain();

    send(0, 8'hFF);
    send(0, 8'h00);
    drain();

    send(0, 8'hC3);
    repeat (3) tick();
    send(0, 8'h3C);
    drain();

    send(0, 8'hA5);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check_quiet(0);
    q0.delete();
    exp_done = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(0, 8'h81);
    drain();

    send(2, 8'h03);
    send(2, 8'h02);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
